// File: rtl/clk_rst_ctrl_pkg.sv
// Shared types and constants for the processor clock/reset controller:
// FSM state encoding, phase indices, hold-counter width and a phase decoder.
`timescale 1ns/1ps
package clk_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int HOLD_CNT_W = 8;

  localparam logic [1:0] PHASE_IMEM    = 2'd0;
  localparam logic [1:0] PHASE_REGFILE = 2'd1;
  localparam logic [1:0] PHASE_DMEM    = 2'd2;
  localparam logic [1:0] PHASE_PROC    = 2'd3;

  // One-hot enable vector {proc, dmem, regfile, imem} for a phase index.
  function automatic logic [3:0] phase_onehot(input logic [1:0] p);
    logic [3:0] oh;
    oh = 4'b0000;
    case (p)
      PHASE_IMEM:    oh = 4'b0001;
      PHASE_REGFILE: oh = 4'b0010;
      PHASE_DMEM:    oh = 4'b0100;
      PHASE_PROC:    oh = 4'b1000;
      default:       oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/reset_stretcher.sv
// Keeps sys_reset high for RST_HOLD_CYCLES clock edges after reset is
// released. hold_done marks the edge on which the stretched reset ends, so
// the controller FSM can leave HOLD on exactly that same edge.
`timescale 1ns/1ps
module reset_stretcher
  import clk_rst_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  output logic sys_reset,
  output logic hold_done
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD_CYCLES - 1);

  logic [HOLD_CNT_W-1:0] hold_count;

  assign hold_done = sys_reset && (hold_count == HOLD_LAST);

  // Count edges while stretching; drop sys_reset on the last counted edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_count <= '0;
      sys_reset  <= 1'b1;
    end else if (sys_reset) begin
      hold_count <= hold_count + 1'b1;
      if (hold_done) begin
        sys_reset <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_rst_ctrl.sv
// Clock/reset controller for a four-phase multi-cycle processor.
// After the stretched reset it sequences imem -> regfile -> dmem -> proc
// enables and counts completed processor cycles.
// Optional run budget: define CLK_RST_CTRL_CYCLE_LIMIT_EN to halt after
// MAX_CYCLES processor cycles (MAX_CYCLES = 0 means unlimited). Without the
// macro halt is tied low and the controller runs forever.
`timescale 1ns/1ps
module clk_rst_ctrl
  import clk_rst_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 4,
  parameter int unsigned MAX_CYCLES      = 150
) (
  input  logic        clock,
  input  logic        reset,
  output logic        sys_reset,
  output logic        imem_en,
  output logic        regfile_en,
  output logic        dmem_en,
  output logic        proc_en,
  output logic [1:0]  phase,
  output logic [31:0] cycle_count,
  output logic        halt
);

  state_t      state;
  logic [3:0]  enables;
  logic        hold_done;
  logic [31:0] cycle_next;
  logic        budget_hit;

  reset_stretcher #(
    .RST_HOLD_CYCLES(RST_HOLD_CYCLES)
  ) u_reset_stretcher (
    .clock     (clock),
    .reset     (reset),
    .sys_reset (sys_reset),
    .hold_done (hold_done)
  );

  assign {proc_en, dmem_en, regfile_en, imem_en} = enables;

  // Natural 32-bit wrap when no budget stops the count.
  assign cycle_next = cycle_count + 32'd1;

`ifdef CLK_RST_CTRL_CYCLE_LIMIT_EN
  logic halt_flag;

  assign halt       = halt_flag;
  assign budget_hit = (MAX_CYCLES != 0) && (cycle_next == MAX_CYCLES);
`else
  assign halt       = 1'b0;
  assign budget_hit = 1'b0;
`endif

  // Controller FSM: wait out the stretched reset, rotate phases, stop on budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      enables     <= '0;
      phase       <= PHASE_IMEM;
      cycle_count <= '0;
`ifdef CLK_RST_CTRL_CYCLE_LIMIT_EN
      halt_flag   <= 1'b0;
`endif
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_done) begin
            state   <= RUN;
            phase   <= PHASE_IMEM;
            enables <= phase_onehot(PHASE_IMEM);
          end
        end
        RUN: begin
          if (phase == PHASE_PROC) begin
            cycle_count <= cycle_next;
            phase       <= PHASE_IMEM;
            if (budget_hit) begin
              state   <= HALTED;
              enables <= '0;
`ifdef CLK_RST_CTRL_CYCLE_LIMIT_EN
              halt_flag <= 1'b1;
`endif
            end else begin
              enables <= phase_onehot(PHASE_IMEM);
            end
          end else begin
            phase   <= phase + 2'd1;
            enables <= phase_onehot(phase + 2'd1);
          end
        end
        HALTED: begin
          enables <= '0;
          phase   <= PHASE_IMEM;
        end
        default: begin
          state   <= HOLD;
          enables <= '0;
          phase   <= PHASE_IMEM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Scoreboard bench for clk_rst_ctrl. The driver pushes the expected output
// snapshot for every clock cycle into a queue; a monitor on the falling edge
// pops and compares against the selected DUT instance.
// dut0: RST_HOLD_CYCLES=4, MAX_CYCLES=150. dut1: RST_HOLD_CYCLES=1, MAX_CYCLES=2.
// Expectations follow CLK_RST_CTRL_CYCLE_LIMIT_EN when it is defined.
`timescale 1ns/1ps
module tb_clk_rst_ctrl;

  typedef struct packed {
    logic        sys_reset;
    logic [3:0]  en;
    logic [1:0]  phase;
    logic [31:0] count;
    logic        halt;
  } obs_t;

`ifdef CLK_RST_CTRL_CYCLE_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset0;
  logic reset1;

  logic        sys_reset0, imem0, regfile0, dmem0, proc0, halt0;
  logic [1:0]  phase0;
  logic [31:0] count0;
  logic        sys_reset1, imem1, regfile1, dmem1, proc1, halt1;
  logic [1:0]  phase1;
  logic [31:0] count1;

  obs_t obs0;
  obs_t obs1;

  obs_t  exp_q[$];
  int    sel_q[$];
  string name_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  clk_rst_ctrl #(.RST_HOLD_CYCLES(4), .MAX_CYCLES(150)) dut0 (
    .clock       (clock),
    .reset       (reset0),
    .sys_reset   (sys_reset0),
    .imem_en     (imem0),
    .regfile_en  (regfile0),
    .dmem_en     (dmem0),
    .proc_en     (proc0),
    .phase       (phase0),
    .cycle_count (count0),
    .halt        (halt0)
  );

  clk_rst_ctrl #(.RST_HOLD_CYCLES(1), .MAX_CYCLES(2)) dut1 (
    .clock       (clock),
    .reset       (reset1),
    .sys_reset   (sys_reset1),
    .imem_en     (imem1),
    .regfile_en  (regfile1),
    .dmem_en     (dmem1),
    .proc_en     (proc1),
    .phase       (phase1),
    .cycle_count (count1),
    .halt        (halt1)
  );

  assign obs0 = {sys_reset0, {proc0, dmem0, regfile0, imem0}, phase0, count0, halt0};
  assign obs1 = {sys_reset1, {proc1, dmem1, regfile1, imem1}, phase1, count1, halt1};

  // Values every output must show while reset or the stretched reset is active.
  function automatic obs_t reset_obs();
    obs_t e;
    e.sys_reset = 1'b1;
    e.en        = 4'b0000;
    e.phase     = 2'd0;
    e.count     = 32'd0;
    e.halt      = 1'b0;
    return e;
  endfunction

  // State after RUN edge k (k = 0 is the edge leaving HOLD).
  function automatic obs_t run_exp(input int k, input int max_cycles);
    obs_t e;
    e.sys_reset = 1'b0;
    e.halt      = 1'b0;
    if (LIMIT && max_cycles != 0 && (k / 4) >= max_cycles) begin
      e.en    = 4'b0000;
      e.phase = 2'd0;
      e.count = 32'(max_cycles);
      e.halt  = 1'b1;
    end else begin
      e.en    = 4'b0001 << (k % 4);
      e.phase = 2'(k % 4);
      e.count = 32'(k / 4);
    end
    return e;
  endfunction

  task automatic push_expect(input int sel, input string nm, input obs_t e);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  // One cycle of stimulus: queue the snapshot expected at the next falling edge.
  task automatic apply_stimulus(input int sel, input string nm, input obs_t e);
    push_expect(sel, nm, e);
    @(negedge clock);
    #1;
  endtask

  task automatic check_output();
    obs_t  e;
    obs_t  a;
    int    sel;
    string nm;
    e   = exp_q.pop_front();
    sel = sel_q.pop_front();
    nm  = name_q.pop_front();
    a   = (sel == 0) ? obs0 : obs1;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: actual sys_reset=%0b en=%b phase=%0d cycle_count=%0d halt=%0b, required sys_reset=%0b en=%b phase=%0d cycle_count=%0d halt=%0b",
               nm, sel, a.sys_reset, a.en, a.phase, a.count, a.halt,
               e.sys_reset, e.en, e.phase, e.count, e.halt);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare away from the rising edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      check_output();
    end
  end

  initial begin
    reset0 = 1'b0;
    reset1 = 1'b0;
    #2;
    reset0 = 1'b1;
    reset1 = 1'b1;
    @(negedge clock);
    #1;

    $display("[TB] dut0: reset held for three edges, then four-edge hold");
    repeat (3) apply_stimulus(0, "reset_high", reset_obs());
    reset0 = 1'b0;
    repeat (3) apply_stimulus(0, "hold_edge", reset_obs());
    apply_stimulus(0, "hold_exit", run_exp(0, 150));

    $display("[TB] dut0: phase rotation and cycle counting");
    for (int k = 1; k <= 29; k++) begin
      apply_stimulus(0, $sformatf("run_a k=%0d", k), run_exp(k, 150));
    end

    $display("[TB] dut0: async reset in phase 2 at cycle_count 7");
    push_expect(0, "async_reset", reset_obs());
    @(posedge clock);
    #1;
    reset0 = 1'b1;
    @(negedge clock);
    #1;
    apply_stimulus(0, "reset_mid_run", reset_obs());
    reset0 = 1'b0;
    repeat (3) apply_stimulus(0, "rehold_edge", reset_obs());
    apply_stimulus(0, "rehold_exit", run_exp(0, 150));

    $display("[TB] dut0: long run through the cycle budget");
    for (int k = 1; k <= 650; k++) begin
      apply_stimulus(0, $sformatf("run_b k=%0d", k), run_exp(k, 150));
    end

    $display("[TB] dut1: single-edge hold, small budget");
    reset1 = 1'b0;
    apply_stimulus(1, "hold1_exit", run_exp(0, 2));
    for (int k = 1; k <= 24; k++) begin
      apply_stimulus(1, $sformatf("run_c k=%0d", k), run_exp(k, 2));
    end

    $display("[TB] dut1: reset from late state and restart");
    reset1 = 1'b1;
    apply_stimulus(1, "reset1_again", reset_obs());
    reset1 = 1'b0;
    apply_stimulus(1, "rehold1_exit", run_exp(0, 2));
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1, $sformatf("run_d k=%0d", k), run_exp(k, 2));
    end

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_rst_ctrl.md
CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 4: clock edges for which sys_reset stays high after reset deasserts (legal 1..255).
REQ-002 SHALL have parameter MAX_CYCLES, default 150: processor cycles before halt (0 = unlimited).
REQ-003 SHALL have port clock  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sys_reset  output  1  stretched reset to the processor datapath, regfile, imem and dmem.
REQ-006 SHALL have port imem_en  output  1  instruction-memory phase enable.
REQ-007 SHALL have port regfile_en  output  1  register-file phase enable.
REQ-008 SHALL have port dmem_en  output  1  data-memory phase enable.
REQ-009 SHALL have port proc_en  output  1  processor commit (PC/writeback) phase enable.
REQ-010 SHALL have port phase  output  2  current phase index, 0..3.
REQ-011 SHALL have port cycle_count  output  32  completed processor cycles.
REQ-012 SHALL have port halt  output  1  sticky run-budget-exhausted flag.

Function
REQ-013 SHALL implement FSM states HOLD, RUN and HALTED.
REQ-014 SHALL, in HOLD, increment an 8-bit hold counter each edge and move to RUN on the edge where it equals RST_HOLD_CYCLES-1.
REQ-015 SHALL, on the HOLD->RUN edge, clear sys_reset, set phase=0 and imem_en=1 together.
REQ-016 SHALL, in RUN, advance phase 0->1->2->3->0 each edge.
REQ-017 SHALL drive one-hot registered enables: phase 0 imem_en, 1 regfile_en, 2 dmem_en, 3 proc_en; none high outside RUN.
REQ-018 SHALL increment cycle_count on each edge leaving phase 3.
REQ-019 SHALL, with MAX_CYCLES nonzero, enter HALTED on the edge where cycle_count becomes MAX_CYCLES, setting halt=1 on that edge.
REQ-020 SHALL, in HALTED, hold all enables at 0, freeze cycle_count and phase=0, keep sys_reset=0; exit only via reset.
REQ-021 SHALL wrap cycle_count 0xFFFFFFFF->0 when no halt applies.
REQ-022 SHALL give reset priority over every other event, including the HOLD->RUN and RUN->HALTED edges.

Reset
REQ-023 SHALL, asynchronously on reset high, force state HOLD, hold counter 0, sys_reset=1, all enables 0, phase=0, cycle_count=0, halt=0.
REQ-024 SHALL apply REQ-023 identically when reset occurs mid-RUN or in HALTED, then repeat the full hold sequence after release.

Configuration
REQ-025 SHALL compile the run-budget logic (REQ-019, REQ-020, halt) only when CLK_RST_CTRL_CYCLE_LIMIT_EN is defined.
REQ-026 SHALL, without CLK_RST_CTRL_CYCLE_LIMIT_EN, tie halt to 0, never enter HALTED, and ignore MAX_CYCLES.

Structure
REQ-027 SHALL take the FSM state typedef, phase index constants and hold-counter width from package clk_rst_ctrl_pkg.
REQ-028 SHALL place the hold counter and sys_reset generation in sub-module reset_stretcher; phase, enables, counters and FSM stay in clk_rst_ctrl.

Verification
REQ-029 SHALL cover: reset high 3 edges, release -> sys_reset high for exactly 4 more edges; on 4th edge sys_reset=0, phase=0, imem_en=1.
REQ-030 SHALL cover: 12 RUN cycles -> enables imem,regfile,dmem,proc repeated 3 times, exactly one high per cycle, cycle_count=3.
REQ-031 SHALL cover: macro defined, MAX_CYCLES=150 -> halt rises at RUN edge 600 with cycle_count=150, enables 0 and values frozen for 50 further cycles.
REQ-032 SHALL cover: reset asserted between edges in phase 2 at cycle_count=7 -> outputs reach REQ-023 values with no clock edge; re-release repeats 4-edge hold.
REQ-033 SHALL cover: macro undefined, MAX_CYCLES=2 -> after 20 RUN cycles halt=0, cycle_count=5, enables still cycling.
REQ-034 SHALL cover: RST_HOLD_CYCLES=1 -> sys_reset falls on first edge after release, imem_en=1 that cycle.
